// File: rtl/draw_rect_ctl_pkg.sv
// Shared screen/sprite constants and the control FSM state encoding
// for the rectangle sprite overlay.
package draw_rect_ctl_pkg;

    localparam int POS_W         = 12;
    localparam int VEL_W         = 8;

    localparam int SCREEN_WIDTH  = 800;
    localparam int SCREEN_HEIGHT = 600;
    localparam int RECT_WIDTH    = 48;
    localparam int RECT_HEIGHT   = 64;

    localparam int GRAVITY_DEF        = 1;
    localparam int BOUNCE_SHIFT_DEF   = 2;
    localparam int MIN_BOUNCE_VEL_DEF = 4;
    localparam int VEL_MAX_DEF        = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FALL = 2'd1,
        RISE = 2'd2,
        REST = 2'd3
    } state_e;

endpackage

// File: rtl/draw_rect_ctl_if.sv
// Mouse/vblank inputs and sprite position outputs of the sprite control stage.
interface draw_rect_ctl_if;
    import draw_rect_ctl_pkg::*;

    logic             vblnk_in;
    logic [POS_W-1:0] mouse_xpos;
    logic [POS_W-1:0] mouse_ypos;
    logic             mouse_left;
    logic [POS_W-1:0] xpos;
    logic [POS_W-1:0] ypos;
    logic             moving;

    modport master (
        output vblnk_in, mouse_xpos, mouse_ypos, mouse_left,
        input  xpos, ypos, moving
    );

    modport slave (
        input  vblnk_in, mouse_xpos, mouse_ypos, mouse_left,
        output xpos, ypos, moving
    );

endinterface

// File: rtl/draw_rect_ctl_edge_detect.sv
// One-cycle pulse on each rising edge of a pclk-domain level.
module edge_detect (
    input  logic pclk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);

    logic din_q;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) din_q <= 1'b0;
        else        din_q <= din;
    end

    assign pulse = din & ~din_q;

endmodule

// File: rtl/draw_rect_ctl.sv
// Sprite position control: tracks the mouse while idle, and on a click drops the
// sprite under gravity with damped floor bounces; positions change only on frame ticks.
module draw_rect_ctl
    import draw_rect_ctl_pkg::*;
#(
    parameter int GRAVITY        = GRAVITY_DEF,
    parameter int BOUNCE_SHIFT   = BOUNCE_SHIFT_DEF,
    parameter int MIN_BOUNCE_VEL = MIN_BOUNCE_VEL_DEF,
    parameter int VEL_MAX        = VEL_MAX_DEF
) (
    input  logic           pclk,
    input  logic           rst_n,
    draw_rect_ctl_if.slave bus
);

    localparam logic        [POS_W-1:0] XMAX_U  = POS_W'(SCREEN_WIDTH - RECT_WIDTH);
    localparam logic        [POS_W-1:0] FLOOR_U = POS_W'(SCREEN_HEIGHT - RECT_HEIGHT);
    localparam logic signed [POS_W:0]   FLOOR_S = (POS_W+1)'(SCREEN_HEIGHT - RECT_HEIGHT);
    localparam logic        [VEL_W-1:0] GRAV_V  = VEL_W'(GRAVITY);
    localparam logic        [VEL_W-1:0] MINB_V  = VEL_W'(MIN_BOUNCE_VEL);
    localparam logic        [VEL_W-1:0] VMAX_V  = VEL_W'(VEL_MAX);

    state_e           state_q;
    logic [POS_W-1:0] xpos_q;
    logic [POS_W-1:0] ypos_q;
    logic [VEL_W-1:0] vel_q;
    logic             moving_q;

    logic tick;
    logic click;

    edge_detect u_tick_ed (
        .pclk  (pclk),
        .rst_n (rst_n),
        .din   (bus.vblnk_in),
        .pulse (tick)
    );

    edge_detect u_click_ed (
        .pclk  (pclk),
        .rst_n (rst_n),
        .din   (bus.mouse_left),
        .pulse (click)
    );

    function automatic logic [POS_W-1:0] min_u(input logic [POS_W-1:0] v,
                                               input logic [POS_W-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    // Clamp a signed 13-bit vertical result into [0, FLOOR].
    function automatic logic [POS_W-1:0] clamp_y(input logic signed [POS_W:0] v);
        if (v < $signed((POS_W+1)'(0))) return '0;
        else if (v > FLOOR_S)          return FLOOR_U;
        else                           return v[POS_W-1:0];
    endfunction

    function automatic logic [VEL_W-1:0] vel_inc_sat(input logic [VEL_W-1:0] v);
        logic [VEL_W:0] s;
        s = {1'b0, v} + {1'b0, GRAV_V};
        return (s > {1'b0, VMAX_V}) ? VMAX_V : s[VEL_W-1:0];
    endfunction

    // Vertical arithmetic is widened by one bit so neither direction can wrap.
    logic signed [POS_W:0]   fall_sum;
    logic signed [POS_W:0]   rise_diff;
    logic        [VEL_W-1:0] vel_b;

    assign fall_sum  = $signed({1'b0, ypos_q}) + $signed({{(POS_W+1-VEL_W){1'b0}}, vel_q});
    assign rise_diff = $signed({1'b0, ypos_q}) - $signed({{(POS_W+1-VEL_W){1'b0}}, vel_q});
    assign vel_b     = vel_q - (vel_q >> BOUNCE_SHIFT);

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            xpos_q   <= '0;
            ypos_q   <= '0;
            vel_q    <= '0;
            moving_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tick) begin
                        xpos_q <= min_u(bus.mouse_xpos, XMAX_U);
                        ypos_q <= min_u(bus.mouse_ypos, FLOOR_U);
                    end
                    if (click) begin
                        vel_q    <= '0;
                        state_q  <= FALL;
                        moving_q <= 1'b1;
                    end
                end
                FALL: begin
                    if (tick) begin
                        if (fall_sum >= FLOOR_S) begin
                            ypos_q <= FLOOR_U;
                            if (vel_b < MINB_V) begin
                                vel_q    <= '0;
                                state_q  <= REST;
                                moving_q <= 1'b0;
                            end else begin
                                vel_q   <= vel_b;
                                state_q <= RISE;
                            end
                        end else begin
                            ypos_q <= fall_sum[POS_W-1:0];
                            vel_q  <= vel_inc_sat(vel_q);
                        end
                    end
                end
                RISE: begin
                    if (tick) begin
                        if (vel_q <= GRAV_V) begin
                            vel_q   <= '0;
                            state_q <= FALL;
                        end else begin
                            ypos_q <= clamp_y(rise_diff);
                            vel_q  <= vel_q - GRAV_V;
                        end
                    end
                end
                REST: begin
                    if (click) begin
                        state_q  <= IDLE;
                        moving_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    moving_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.xpos   = xpos_q;
    assign bus.ypos   = ypos_q;
    assign bus.moving = moving_q;

endmodule

// File: tb/tb_draw_rect_ctl.sv
// Bench for draw_rect_ctl: directed scenarios plus random stimulus, every cycle
// compared against a frame-level behavioural model of the sprite.
module tb_draw_rect_ctl;

    localparam int T_FLOOR = 600 - 64;
    localparam int T_XMAX  = 800 - 48;

    logic pclk  = 1'b0;
    logic rst_n = 1'b0;

    draw_rect_ctl_if bus ();

    draw_rect_ctl dut (
        .pclk  (pclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 pclk = ~pclk;

    typedef enum {M_TRACK, M_DROP, M_UP, M_STILL} mphase_e;

    int      m_x, m_y, m_vel;
    mphase_e m_ph;
    bit      m_prev_vb, m_prev_ml;

    int vectors     = 0;
    int miscompares = 0;

    logic [11:0] cur_mx = '0;
    logic [11:0] cur_my = '0;
    logic        cur_ml = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_x = 0; m_y = 0; m_vel = 0; m_ph = M_TRACK;
        m_prev_vb = 1'b0; m_prev_ml = 1'b0;
    endtask

    // One pclk of the sprite behaviour, written in terms of frames and pixels.
    task automatic model_step(input bit vb, input bit ml);
        bit tick, clk_ev;
        int vb2;
        tick   = vb && !m_prev_vb;
        clk_ev = ml && !m_prev_ml;
        m_prev_vb = vb;
        m_prev_ml = ml;
        case (m_ph)
            M_TRACK: begin
                if (tick) begin
                    m_x = (int'(cur_mx) > T_XMAX)  ? T_XMAX  : int'(cur_mx);
                    m_y = (int'(cur_my) > T_FLOOR) ? T_FLOOR : int'(cur_my);
                end
                if (clk_ev) begin
                    m_vel = 0;
                    m_ph  = M_DROP;
                end
            end
            M_DROP: if (tick) begin
                if (m_y + m_vel >= T_FLOOR) begin
                    m_y = T_FLOOR;
                    vb2 = m_vel - m_vel / 4;
                    if (vb2 < 4) begin m_vel = 0;   m_ph = M_STILL; end
                    else         begin m_vel = vb2; m_ph = M_UP;    end
                end else begin
                    m_y   = m_y + m_vel;
                    m_vel = (m_vel + 1 > 255) ? 255 : m_vel + 1;
                end
            end
            M_UP: if (tick) begin
                if (m_vel <= 1) begin
                    m_vel = 0;
                    m_ph  = M_DROP;
                end else begin
                    m_y   = (m_y - m_vel < 0) ? 0 : m_y - m_vel;
                    m_vel = m_vel - 1;
                end
            end
            M_STILL: if (clk_ev) m_ph = M_TRACK;
            default: ;
        endcase
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".xpos"},   {20'd0, bus.xpos}, m_x);
        chk({tag, ".ypos"},   {20'd0, bus.ypos}, m_y);
        chk({tag, ".moving"}, {31'd0, bus.moving}, (m_ph == M_DROP || m_ph == M_UP) ? 1 : 0);
    endtask

    task automatic do_cycle(input bit vb);
        bus.vblnk_in   = vb;
        bus.mouse_xpos = cur_mx;
        bus.mouse_ypos = cur_my;
        bus.mouse_left = cur_ml;
        @(posedge pclk);
        model_step(vb, cur_ml);
        #1;
        check_all("cyc");
    endtask

    task automatic tick_frame();
        do_cycle(1'b1);
        do_cycle(1'b0);
    endtask

    task automatic click();
        cur_ml = 1'b1;
        do_cycle(1'b0);
        cur_ml = 1'b0;
        do_cycle(1'b0);
    endtask

    initial begin
        bus.vblnk_in   = 1'b0;
        bus.mouse_xpos = '0;
        bus.mouse_ypos = '0;
        bus.mouse_left = 1'b0;
        model_reset();

        // Reset state
        #1;
        chk("rst.xpos",   {20'd0, bus.xpos}, 0);
        chk("rst.ypos",   {20'd0, bus.ypos}, 0);
        chk("rst.moving", {31'd0, bus.moving}, 0);
        repeat (3) @(posedge pclk);
        #1 rst_n = 1'b1;

        // Tracking: nothing moves until a tick
        cur_mx = 12'd100; cur_my = 12'd200;
        repeat (3) do_cycle(1'b0);
        chk("trk.hold.x", {20'd0, bus.xpos}, 0);
        do_cycle(1'b1);
        chk("trk.x",      {20'd0, bus.xpos}, 100);
        chk("trk.y",      {20'd0, bus.ypos}, 200);
        chk("trk.moving", {31'd0, bus.moving}, 0);
        do_cycle(1'b0);

        // Clamp to XMAX / FLOOR
        cur_mx = 12'd1000; cur_my = 12'd700;
        tick_frame();
        chk("clamp.x", {20'd0, bus.xpos}, 752);
        chk("clamp.y", {20'd0, bus.ypos}, 536);

        // Full fall from the top; a click mid-fall must be ignored
        cur_mx = 12'd300; cur_my = 12'd0;
        tick_frame();
        chk("fall.start.y", {20'd0, bus.ypos}, 0);
        click();
        chk("fall.moving", {31'd0, bus.moving}, 1);
        for (int i = 1; i <= 33; i++) begin
            tick_frame();
            if (i == 10) click();
        end
        chk("fall.t33.y", {20'd0, bus.ypos}, 528);
        chk("fall.t33.x", {20'd0, bus.xpos}, 300);
        tick_frame();
        chk("fall.t34.y",      {20'd0, bus.ypos}, 536);
        chk("fall.t34.moving", {31'd0, bus.moving}, 1);
        tick_frame();
        chk("rise.t35.y", {20'd0, bus.ypos}, 511);

        // Asynchronous reset mid-rise, asserted between clock edges
        #1 rst_n = 1'b0;
        #1;
        chk("arst.xpos",   {20'd0, bus.xpos}, 0);
        chk("arst.ypos",   {20'd0, bus.ypos}, 0);
        chk("arst.moving", {31'd0, bus.moving}, 0);
        model_reset();
        repeat (2) @(posedge pclk);
        #1 rst_n = 1'b1;
        cur_mx = 12'd40; cur_my = 12'd50;
        tick_frame();
        chk("arst.trk.x", {20'd0, bus.xpos}, 40);
        chk("arst.trk.y", {20'd0, bus.ypos}, 50);

        // Settle near the floor into REST, then back to tracking
        cur_mx = 12'd50; cur_my = 12'd530;
        tick_frame();
        click();
        tick_frame(); chk("settle.t1.y", {20'd0, bus.ypos}, 530);
        tick_frame(); chk("settle.t2.y", {20'd0, bus.ypos}, 531);
        tick_frame(); chk("settle.t3.y", {20'd0, bus.ypos}, 533);
        tick_frame(); chk("settle.t4.y", {20'd0, bus.ypos}, 536);
        chk("settle.moving", {31'd0, bus.moving}, 0);
        cur_mx = 12'd60; cur_my = 12'd70;
        tick_frame();
        chk("rest.hold.y", {20'd0, bus.ypos}, 536);
        click();
        tick_frame();
        chk("rest.trk.x", {20'd0, bus.xpos}, 60);
        chk("rest.trk.y", {20'd0, bus.ypos}, 70);

        // Tick and click together in IDLE
        cur_mx = 12'd10; cur_my = 12'd20;
        cur_ml = 1'b1;
        do_cycle(1'b1);
        cur_ml = 1'b0;
        chk("tc.x",      {20'd0, bus.xpos}, 10);
        chk("tc.y",      {20'd0, bus.ypos}, 20);
        chk("tc.moving", {31'd0, bus.moving}, 1);
        repeat (3) do_cycle(1'b0);
        chk("tc.hold.y", {20'd0, bus.ypos}, 20);
        tick_frame();
        chk("tc.t1.y", {20'd0, bus.ypos}, 20);
        tick_frame();
        chk("tc.t2.y", {20'd0, bus.ypos}, 21);

        // Random mouse motion, clicks and frame ticks
        for (int n = 0; n < 6000; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                cur_mx = 12'($urandom_range(0, 4095));
                cur_my = 12'($urandom_range(0, 1023));
            end
            cur_ml = ($urandom_range(0, 23) == 0);
            do_cycle($urandom_range(0, 2) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
